// File: rtl/ibex_cheri_mem_authq_pkg.sv
// Shared types, exception indices and capability field decoders for the CHERI memory-authority queue.
// The decoders stand in for the wrap64 helpers on an uncompressed 91-bit capability layout.
package ibex_cheri_mem_authq_pkg;

  localparam int unsigned CheriExcWidth = 6;

  localparam int unsigned ExcTagIdx    = 0;
  localparam int unsigned ExcSealIdx   = 1;
  localparam int unsigned ExcLoadIdx   = 2;
  localparam int unsigned ExcStoreIdx  = 3;
  localparam int unsigned ExcExecIdx   = 4;
  localparam int unsigned ExcLengthIdx = 5;

  localparam int unsigned PermitExecuteIndex = 1;
  localparam int unsigned PermitLoadIndex    = 2;
  localparam int unsigned PermitStoreIndex   = 3;

  // Layout: [90] tag | [89:83] kind | [82:71] perms | [70:39] base | [38:6] top | [5:0] reserved
  localparam int unsigned CapLayoutWidth = 91;

  typedef logic [CapLayoutWidth-1:0] cap_t;

  typedef enum logic [1:0] {
    MemWord   = 2'b00,
    MemHalf   = 2'b01,
    MemByte   = 2'b10,
    MemDouble = 2'b11
  } mem_type_e;

  typedef struct packed {
    logic [CheriExcWidth-1:0] exc;
    logic                     upper_exc;
    logic                     is_local;
  } cheri_memq_entry_t;

  function automatic logic cap_is_valid(input cap_t cap);
    return cap[90];
  endfunction

  function automatic logic [6:0] cap_get_kind(input cap_t cap);
    return cap[89:83];
  endfunction

  function automatic logic [11:0] cap_get_perms(input cap_t cap);
    return cap[82:71];
  endfunction

  function automatic logic [31:0] cap_get_base(input cap_t cap);
    return cap[70:39];
  endfunction

  function automatic logic [32:0] cap_get_top(input cap_t cap);
    return cap[38:6];
  endfunction

  function automatic logic [3:0] access_size(input mem_type_e t);
    logic [3:0] size;
    case (t)
      MemWord:   size = 4'd4;
      MemHalf:   size = 4'd2;
      MemByte:   size = 4'd1;
      MemDouble: size = 4'd8;
      default:   size = 4'd4;
    endcase
    return size;
  endfunction

  function automatic logic [1:0] lowest_be_offset(input logic [3:0] be);
    logic [1:0] off;
    casez (be)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/ibex_cheri_mem_authq_if.sv
// Core-side and memory-side handshake bundle of the CHERI memory-authority queue.
// The slave modport is the queue itself; the master modport is the core plus memory environment.
interface ibex_cheri_mem_authq_if #(
  parameter int unsigned CheriCapWidth = 91
);

  logic [CheriCapWidth-1:0] auth_cap;
  logic                     core_req;
  logic                     core_gnt;
  logic                     core_rvalid;
  logic [31:0]              core_addr;
  logic                     core_we;
  logic [1:0]               core_type;
  logic [3:0]               core_be;

  logic                     mem_req;
  logic                     mem_gnt;
  logic                     mem_rvalid;
  logic                     mem_we;

  logic [ibex_cheri_mem_authq_pkg::CheriExcWidth-1:0] exc;
  logic                     instr_upper_exc;
  logic                     spurious_rvalid;

  modport master (
    output auth_cap, core_req, core_addr, core_we, core_type, core_be, mem_gnt, mem_rvalid,
    input  core_gnt, core_rvalid, mem_req, mem_we, exc, instr_upper_exc, spurious_rvalid
  );

  modport slave (
    input  auth_cap, core_req, core_addr, core_we, core_type, core_be, mem_gnt, mem_rvalid,
    output core_gnt, core_rvalid, mem_req, mem_we, exc, instr_upper_exc, spurious_rvalid
  );

endinterface

// File: rtl/ibex_cheri_access_check.sv
// Combinational CHERI authority check of one request against its authorising capability.
// Produces the violation vector and, on the instruction port, the upper-half length flag.
module ibex_cheri_access_check
  import ibex_cheri_mem_authq_pkg::*;
#(
  parameter bit          DataMem       = 1'b1,
  parameter int unsigned CheriCapWidth = 91
) (
  input  logic [CheriCapWidth-1:0] auth_cap,
  input  logic [31:0]              addr,
  input  logic                     we,
  input  logic [1:0]               mem_type,
  input  logic [3:0]               be,
  output logic [CheriExcWidth-1:0] exc_d,
  output logic                     upper_exc_d
);

  cap_t        cap;
  logic        valid;
  logic [6:0]  kind;
  logic [11:0] perms;
  logic [31:0] base;
  logic [32:0] top;
  logic [3:0]  size;
  logic [31:0] addr_actual;
  logic [32:0] end_addr;
  logic [32:0] upper_end;

  assign cap   = cap_t'(auth_cap);
  assign valid = cap_is_valid(cap);
  assign kind  = cap_get_kind(cap);
  assign perms = cap_get_perms(cap);
  assign base  = cap_get_base(cap);
  assign top   = cap_get_top(cap);

  // Instruction fetches are 2-byte parcels at the word address; data sizes follow the access type.
  assign size        = DataMem ? access_size(mem_type_e'(mem_type)) : 4'd2;
  assign addr_actual = {addr[31:2], (DataMem ? lowest_be_offset(be) : 2'b00)};
  assign end_addr    = {1'b0, addr_actual} + {29'd0, size};
  assign upper_end   = {1'b0, addr[31:2], 2'b10} + 33'd2;

  always_comb begin
    exc_d               = '0;
    exc_d[ExcTagIdx]    = ~valid;
    exc_d[ExcSealIdx]   = |kind[6:4];
    exc_d[ExcLoadIdx]   = ~we & ~perms[PermitLoadIndex];
    exc_d[ExcStoreIdx]  = we & ~perms[PermitStoreIndex];
    exc_d[ExcExecIdx]   = DataMem & ~perms[PermitExecuteIndex];
    exc_d[ExcLengthIdx] = (addr_actual < base) | (end_addr > top);
  end

  assign upper_exc_d = ~DataMem & (upper_end > top);

  logic unused_bits;
  assign unused_bits = ^{cap[5:0], kind[3:0], perms[11:4], perms[0], addr[1:0], mem_type, be};

endmodule

// File: rtl/ibex_cheri_mem_authq.sv
// CHERI memory-authority queue: checks each request at grant time and returns its result with the response.
// Define IBEX_CHERI_LOCAL_FAULT_EN to kill violating requests locally instead of forwarding them.
module ibex_cheri_mem_authq
  import ibex_cheri_mem_authq_pkg::*;
#(
  parameter bit          DataMem        = 1'b1,
  parameter int unsigned CheriCapWidth  = 91,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ibex_cheri_mem_authq_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(NumOutstanding + 1);
  localparam int unsigned     PtrW    = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(NumOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NumOutstanding - 1);

  logic [CheriExcWidth-1:0] exc_d;
  logic                     upper_exc_d;
  logic                     kill;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     mem_req;
  logic                     core_gnt;
  logic                     core_rvalid;

  logic [CntW-1:0]          count_q;
  logic [PtrW-1:0]          wptr_q;
  logic [PtrW-1:0]          rptr_q;
  cheri_memq_entry_t        queue_q [NumOutstanding];
  cheri_memq_entry_t        head;
  cheri_memq_entry_t        new_entry;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  ibex_cheri_access_check #(
    .DataMem      (DataMem),
    .CheriCapWidth(CheriCapWidth)
  ) u_check (
    .auth_cap   (bus.auth_cap),
    .addr       (bus.core_addr),
    .we         (bus.core_we),
    .mem_type   (bus.core_type),
    .be         (bus.core_be),
    .exc_d      (exc_d),
    .upper_exc_d(upper_exc_d)
  );

`ifdef IBEX_CHERI_LOCAL_FAULT_EN
  assign kill = |exc_d;
`else
  assign kill = 1'b0;
`endif

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // A killed request is only granted into an empty queue so its local answer cannot overtake older responses.
  assign mem_req  = bus.core_req & ~full & ~kill;
  assign core_gnt = (mem_req & bus.mem_gnt) | (bus.core_req & kill & empty);
  assign push     = bus.core_req & core_gnt;

  assign head        = queue_q[rptr_q];
  assign core_rvalid = ~empty & (head.is_local | bus.mem_rvalid);
  assign pop         = core_rvalid;

  always_comb begin
    new_entry           = '0;
    new_entry.exc       = exc_d;
    new_entry.upper_exc = upper_exc_d;
    new_entry.is_local  = kill;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      queue_q[wptr_q] <= new_entry;
    end
  end

  assign bus.mem_req         = mem_req;
  assign bus.core_gnt        = core_gnt;
  assign bus.core_rvalid     = core_rvalid;
  assign bus.mem_we          = bus.core_we & ~|exc_d;
  assign bus.exc             = core_rvalid ? head.exc : '0;
  assign bus.instr_upper_exc = core_rvalid & head.upper_exc;
  // Memory responses with nothing forwarded at the head are protocol errors and are dropped.
  assign bus.spurious_rvalid = bus.mem_rvalid & (empty | head.is_local);

endmodule

// File: tb/tb_ibex_cheri_mem_authq.sv
// Directed bench for ibex_cheri_mem_authq: a data-port and an instruction-port instance.
// Expectations for killed requests follow IBEX_CHERI_LOCAL_FAULT_EN when it is defined.
module tb_ibex_cheri_mem_authq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [90:0] cap_ok;
  logic [90:0] cap_notag;

  ibex_cheri_mem_authq_if #(.CheriCapWidth(91)) dif ();
  ibex_cheri_mem_authq_if #(.CheriCapWidth(91)) iif ();

  ibex_cheri_mem_authq #(
    .DataMem(1'b1), .CheriCapWidth(91), .NumOutstanding(2)
  ) dut_d (
    .clk_i(clk), .rst_ni(rst_n), .bus(dif)
  );

  ibex_cheri_mem_authq #(
    .DataMem(1'b0), .CheriCapWidth(91), .NumOutstanding(2)
  ) dut_i (
    .clk_i(clk), .rst_ni(rst_n), .bus(iif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [90:0] make_cap(input logic v, input logic [6:0] kind, input logic [11:0] perms,
                                           input logic [31:0] base, input logic [32:0] top);
    return {v, kind, perms, base, top, 6'b0};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic req, input logic [31:0] addr, input logic we, input logic [1:0] typ,
                         input logic [3:0] be, input logic gnt, input logic rv, input logic [90:0] cap);
    dif.core_req   = req;
    dif.core_addr  = addr;
    dif.core_we    = we;
    dif.core_type  = typ;
    dif.core_be    = be;
    dif.mem_gnt    = gnt;
    dif.mem_rvalid = rv;
    dif.auth_cap   = cap;
  endtask

  task automatic drive_i(input logic req, input logic [31:0] addr, input logic gnt, input logic rv,
                         input logic [90:0] cap);
    iif.core_req   = req;
    iif.core_addr  = addr;
    iif.core_we    = 1'b0;
    iif.core_type  = 2'b00;
    iif.core_be    = 4'b0000;
    iif.mem_gnt    = gnt;
    iif.mem_rvalid = rv;
    iif.auth_cap   = cap;
  endtask

  task automatic idle_d();
    drive_d(1'b0, 32'h0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, cap_ok);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({dif.core_gnt, dif.core_rvalid, dif.mem_req, dif.mem_we, dif.instr_upper_exc, dif.spurious_rvalid} !== 6'b0)
      begin failures++; $display("FAIL reset_d_outs got=%b exp=000000", {dif.core_gnt, dif.core_rvalid, dif.mem_req, dif.mem_we, dif.instr_upper_exc, dif.spurious_rvalid}); end
    checks++; if (dif.exc !== 6'h00) begin failures++; $display("FAIL reset_d_exc got=%h exp=00", dif.exc); end
    checks++; if (dut_d.count_q !== 2'd0) begin failures++; $display("FAIL reset_d_count got=%0d exp=0", dut_d.count_q); end
    checks++; if ({iif.core_gnt, iif.core_rvalid, iif.mem_req, iif.instr_upper_exc, iif.spurious_rvalid} !== 5'b0)
      begin failures++; $display("FAIL reset_i_outs got=%b exp=00000", {iif.core_gnt, iif.core_rvalid, iif.mem_req, iif.instr_upper_exc, iif.spurious_rvalid}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pipelined();
    next(); drive_d(1'b1, 32'h1000, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, cap_ok);
    @(negedge clk);
    checks++; if (dif.mem_req !== 1'b1) begin failures++; $display("FAIL pipe_req0 got=%b exp=1", dif.mem_req); end
    checks++; if (dif.core_gnt !== 1'b1) begin failures++; $display("FAIL pipe_gnt0 got=%b exp=1", dif.core_gnt); end
    next(); drive_d(1'b1, 32'h1004, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, cap_ok);
    @(negedge clk);
    checks++; if (dif.core_gnt !== 1'b1) begin failures++; $display("FAIL pipe_gnt1 got=%b exp=1", dif.core_gnt); end
    next(); drive_d(1'b1, 32'h1008, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, cap_ok);
    @(negedge clk);
    checks++; if ({dif.core_gnt, dif.mem_req} !== 2'b00) begin failures++; $display("FAIL pipe_full_gnt got=%b exp=00", {dif.core_gnt, dif.mem_req}); end
    checks++; if (dif.core_rvalid !== 1'b0) begin failures++; $display("FAIL pipe_rv_early got=%b exp=0", dif.core_rvalid); end
    next(); drive_d(1'b1, 32'h1008, 1'b0, 2'b00, 4'hF, 1'b1, 1'b1, cap_ok);
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b1) begin failures++; $display("FAIL pipe_rv0 got=%b exp=1", dif.core_rvalid); end
    checks++; if (dif.exc !== 6'h00) begin failures++; $display("FAIL pipe_exc0 got=%h exp=00", dif.exc); end
    checks++; if (dif.core_gnt !== 1'b0) begin failures++; $display("FAIL pipe_full_pop_gnt got=%b exp=0", dif.core_gnt); end
    next(); drive_d(1'b0, 32'h0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1, cap_ok);
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b1) begin failures++; $display("FAIL pipe_rv1 got=%b exp=1", dif.core_rvalid); end
    checks++; if (dif.exc !== 6'h00) begin failures++; $display("FAIL pipe_exc1 got=%h exp=00", dif.exc); end
    next(); idle_d();
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b0) begin failures++; $display("FAIL pipe_rv_end got=%b exp=0", dif.core_rvalid); end
    checks++; if (dut_d.count_q !== 2'd0) begin failures++; $display("FAIL pipe_count_end got=%0d exp=0", dut_d.count_q); end
  endtask

  task automatic test_length();
    // Legal byte store at the last byte below top: be=1000 puts the access at 0x1FFF.
    next(); drive_d(1'b1, 32'h1FFC, 1'b1, 2'b10, 4'b1000, 1'b0, 1'b0, cap_ok);
    @(negedge clk);
    checks++; if ({dif.mem_req, dif.mem_we, dif.core_gnt} !== 3'b110) begin failures++; $display("FAIL len_legal got=%b exp=110", {dif.mem_req, dif.mem_we, dif.core_gnt}); end
`ifdef IBEX_CHERI_LOCAL_FAULT_EN
    next(); drive_d(1'b1, 32'h2000, 1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, cap_ok);
    @(negedge clk);
    checks++; if ({dif.mem_req, dif.core_gnt, dif.mem_we} !== 3'b010) begin failures++; $display("FAIL len_kill got=%b exp=010", {dif.mem_req, dif.core_gnt, dif.mem_we}); end
    next(); idle_d();
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b1) begin failures++; $display("FAIL len_local_rv got=%b exp=1", dif.core_rvalid); end
    checks++; if (dif.exc !== 6'h20) begin failures++; $display("FAIL len_local_exc got=%h exp=20", dif.exc); end
`else
    next(); drive_d(1'b1, 32'h2000, 1'b1, 2'b10, 4'b0001, 1'b1, 1'b0, cap_ok);
    @(negedge clk);
    checks++; if ({dif.mem_req, dif.core_gnt, dif.mem_we} !== 3'b110) begin failures++; $display("FAIL len_fwd got=%b exp=110", {dif.mem_req, dif.core_gnt, dif.mem_we}); end
    next(); idle_d();
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b0) begin failures++; $display("FAIL len_wait_rv got=%b exp=0", dif.core_rvalid); end
    next(); drive_d(1'b0, 32'h0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1, cap_ok);
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b1) begin failures++; $display("FAIL len_fwd_rv got=%b exp=1", dif.core_rvalid); end
    checks++; if (dif.exc !== 6'h20) begin failures++; $display("FAIL len_fwd_exc got=%h exp=20", dif.exc); end
`endif
    next(); idle_d();
    @(negedge clk);
    checks++; if ({dif.core_rvalid, dif.exc} !== 7'b0) begin failures++; $display("FAIL len_end got=%b exp=0", {dif.core_rvalid, dif.exc}); end
  endtask

  task automatic test_kill_behind();
    next(); drive_d(1'b1, 32'h1000, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, cap_ok);
    @(negedge clk);
    checks++; if (dif.core_gnt !== 1'b1) begin failures++; $display("FAIL kb_load_gnt got=%b exp=1", dif.core_gnt); end
`ifdef IBEX_CHERI_LOCAL_FAULT_EN
    next(); drive_d(1'b1, 32'h1004, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, cap_notag);
    @(negedge clk);
    checks++; if ({dif.core_gnt, dif.mem_req} !== 2'b00) begin failures++; $display("FAIL kb_hold0 got=%b exp=00", {dif.core_gnt, dif.mem_req}); end
    next();
    @(negedge clk);
    checks++; if (dif.core_gnt !== 1'b0) begin failures++; $display("FAIL kb_hold1 got=%b exp=0", dif.core_gnt); end
    next(); dif.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if ({dif.core_rvalid, dif.core_gnt} !== 2'b10) begin failures++; $display("FAIL kb_load_rv got=%b exp=10", {dif.core_rvalid, dif.core_gnt}); end
    checks++; if (dif.exc !== 6'h00) begin failures++; $display("FAIL kb_load_exc got=%h exp=00", dif.exc); end
    next(); dif.mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if ({dif.core_gnt, dif.mem_req} !== 2'b10) begin failures++; $display("FAIL kb_kill_gnt got=%b exp=10", {dif.core_gnt, dif.mem_req}); end
    next(); idle_d();
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b1) begin failures++; $display("FAIL kb_local_rv got=%b exp=1", dif.core_rvalid); end
    checks++; if (dif.exc !== 6'h01) begin failures++; $display("FAIL kb_local_exc got=%h exp=01", dif.exc); end
`else
    next(); drive_d(1'b1, 32'h1004, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, cap_notag);
    @(negedge clk);
    checks++; if ({dif.core_gnt, dif.mem_req} !== 2'b11) begin failures++; $display("FAIL kb_fwd_gnt got=%b exp=11", {dif.core_gnt, dif.mem_req}); end
    next(); idle_d();
    next(); dif.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b1) begin failures++; $display("FAIL kb_load_rv got=%b exp=1", dif.core_rvalid); end
    checks++; if (dif.exc !== 6'h00) begin failures++; $display("FAIL kb_load_exc got=%h exp=00", dif.exc); end
    next();
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b1) begin failures++; $display("FAIL kb_tag_rv got=%b exp=1", dif.core_rvalid); end
    checks++; if (dif.exc !== 6'h01) begin failures++; $display("FAIL kb_tag_exc got=%h exp=01", dif.exc); end
`endif
    next(); idle_d();
    @(negedge clk);
    checks++; if (dif.core_rvalid !== 1'b0) begin failures++; $display("FAIL kb_end_rv got=%b exp=0", dif.core_rvalid); end
  endtask

  task automatic test_perms();
    // Request line stays low: only the combinational write mask is observed.
    next(); drive_d(1'b0, 32'h1000, 1'b1, 2'b00, 4'hF, 1'b0, 1'b0, make_cap(1'b1, 7'h00, 12'hFF7, 32'h1000, 33'h2000));
    @(negedge clk);
    checks++; if (dif.mem_we !== 1'b0) begin failures++; $display("FAIL perm_store got=%b exp=0", dif.mem_we); end
    dif.auth_cap = make_cap(1'b1, 7'h10, 12'hFFF, 32'h1000, 33'h2000);
    #1;
    checks++; if (dif.mem_we !== 1'b0) begin failures++; $display("FAIL perm_seal got=%b exp=0", dif.mem_we); end
    dif.auth_cap = make_cap(1'b1, 7'h00, 12'hFFD, 32'h1000, 33'h2000);
    #1;
    checks++; if (dif.mem_we !== 1'b0) begin failures++; $display("FAIL perm_exec got=%b exp=0", dif.mem_we); end
    dif.auth_cap = make_cap(1'b1, 7'h0F, 12'hFFF, 32'h1000, 33'h2000);
    #1;
    checks++; if (dif.mem_we !== 1'b1) begin failures++; $display("FAIL perm_kind_low got=%b exp=1", dif.mem_we); end
    next(); drive_d(1'b0, 32'h0FFC, 1'b1, 2'b00, 4'hF, 1'b0, 1'b0, cap_ok);
    @(negedge clk);
    checks++; if (dif.mem_we !== 1'b0) begin failures++; $display("FAIL perm_below_base got=%b exp=0", dif.mem_we); end
    next(); idle_d();
  endtask

  task automatic test_instr();
    next(); drive_i(1'b1, 32'h1000, 1'b1, 1'b0, make_cap(1'b1, 7'h00, 12'hFFF, 32'h1000, 33'h1002));
    @(negedge clk);
    checks++; if ({iif.core_gnt, iif.mem_req} !== 2'b11) begin failures++; $display("FAIL ins_gnt got=%b exp=11", {iif.core_gnt, iif.mem_req}); end
    checks++; if (iif.instr_upper_exc !== 1'b0) begin failures++; $display("FAIL ins_upper_idle got=%b exp=0", iif.instr_upper_exc); end
    next(); iif.core_req = 1'b0; iif.mem_gnt = 1'b0; iif.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if (iif.core_rvalid !== 1'b1) begin failures++; $display("FAIL ins_rv got=%b exp=1", iif.core_rvalid); end
    checks++; if (iif.exc !== 6'h00) begin failures++; $display("FAIL ins_exc got=%h exp=00", iif.exc); end
    checks++; if (iif.instr_upper_exc !== 1'b1) begin failures++; $display("FAIL ins_upper got=%b exp=1", iif.instr_upper_exc); end
    next(); drive_i(1'b1, 32'h1000, 1'b1, 1'b0, make_cap(1'b1, 7'h00, 12'hFFF, 32'h1000, 33'h1004));
    next(); iif.core_req = 1'b0; iif.mem_gnt = 1'b0; iif.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if ({iif.core_rvalid, iif.instr_upper_exc} !== 2'b10) begin failures++; $display("FAIL ins_upper_ok got=%b exp=10", {iif.core_rvalid, iif.instr_upper_exc}); end
    next(); drive_i(1'b0, 32'h0, 1'b0, 1'b0, cap_ok);
  endtask

  task automatic test_top_boundary();
    next(); drive_d(1'b1, 32'hFFFF_FFF8, 1'b0, 2'b11, 4'hF, 1'b1, 1'b0, make_cap(1'b1, 7'h00, 12'hFFF, 32'h0, 33'h1_0000_0000));
    @(negedge clk);
    checks++; if ({dif.core_gnt, dif.mem_req} !== 2'b11) begin failures++; $display("FAIL top_gnt got=%b exp=11", {dif.core_gnt, dif.mem_req}); end
    next(); dif.core_req = 1'b0; dif.mem_gnt = 1'b0; dif.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if ({dif.core_rvalid, dif.exc} !== 7'b1_000000) begin failures++; $display("FAIL top_rv got=%b exp=1000000", {dif.core_rvalid, dif.exc}); end
    next(); drive_d(1'b0, 32'hFFFF_FFF8, 1'b1, 2'b11, 4'hF, 1'b0, 1'b0, make_cap(1'b1, 7'h00, 12'hFFF, 32'h0, 33'h1_0000_0000));
    @(negedge clk);
    checks++; if (dif.mem_we !== 1'b1) begin failures++; $display("FAIL top_store_ok got=%b exp=1", dif.mem_we); end
    dif.auth_cap = make_cap(1'b1, 7'h00, 12'hFFF, 32'h0, 33'h0_FFFF_FFFF);
    #1;
    checks++; if (dif.mem_we !== 1'b0) begin failures++; $display("FAIL top_store_short got=%b exp=0", dif.mem_we); end
    next(); idle_d();
  endtask

  task automatic test_spurious_reset();
    next(); dif.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if ({dif.spurious_rvalid, dif.core_rvalid} !== 2'b10) begin failures++; $display("FAIL spur_empty got=%b exp=10", {dif.spurious_rvalid, dif.core_rvalid}); end
    next(); dif.mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (dif.spurious_rvalid !== 1'b0) begin failures++; $display("FAIL spur_clear got=%b exp=0", dif.spurious_rvalid); end
    next(); drive_d(1'b1, 32'h1000, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, cap_ok);
    next(); drive_d(1'b1, 32'h1004, 1'b0, 2'b00, 4'hF, 1'b1, 1'b0, cap_ok);
    next(); idle_d();
    @(negedge clk);
    checks++; if (dut_d.count_q !== 2'd2) begin failures++; $display("FAIL rst_pre_count got=%0d exp=2", dut_d.count_q); end
    next();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dut_d.count_q !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", dut_d.count_q); end
    checks++; if ({dif.core_gnt, dif.core_rvalid, dif.mem_req, dif.mem_we, dif.exc, dif.instr_upper_exc, dif.spurious_rvalid} !== 12'b0)
      begin failures++; $display("FAIL rst_outs got=%b exp=0", {dif.core_gnt, dif.core_rvalid, dif.mem_req, dif.mem_we, dif.exc, dif.instr_upper_exc, dif.spurious_rvalid}); end
    @(negedge clk);
    rst_n = 1'b1;
    next(); dif.mem_rvalid = 1'b1;
    @(negedge clk);
    checks++; if ({dif.spurious_rvalid, dif.core_rvalid} !== 2'b10) begin failures++; $display("FAIL rst_inflight got=%b exp=10", {dif.spurious_rvalid, dif.core_rvalid}); end
    next(); idle_d();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timeout");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    cap_ok    = make_cap(1'b1, 7'h00, 12'hFFF, 32'h1000, 33'h2000);
    cap_notag = make_cap(1'b0, 7'h00, 12'hFFF, 32'h1000, 33'h2000);
    idle_d();
    drive_i(1'b0, 32'h0, 1'b0, 1'b0, cap_ok);
    test_reset();
    test_pipelined();
    test_length();
    test_kill_behind();
    test_perms();
    test_instr();
    test_top_boundary();
    test_spurious_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
